// File: rtl/rca_pkg.sv
// Purpose: shared constants for the ripple-carry adder block.
// Latency: n/a (declarations only).
// Backpressure: n/a (declarations only).
package rca_pkg;

    // Default operand width used by the adder and its bus interface.
    localparam int RCA_WIDTH_DEFAULT = 4;

    // Legal width range for the adder.
    localparam int RCA_WIDTH_MIN = 1;
    localparam int RCA_WIDTH_MAX = 32;

endpackage : rca_pkg

// File: rtl/rca_if.sv
// Purpose: operand/result bus for the ripple-carry adder.
// Latency: n/a (wires only); result is one clock behind operands.
// Backpressure: none; a new operand set may be presented every cycle.
//
// Signals:
//   a, b   - unsigned addends (WIDTH bits), driven by the master
//   cin    - carry into bit 0, driven by the master
//   sum    - registered sum bits, driven by the slave
//   c4     - registered carry out of the MSB, driven by the slave
interface rca_if
    import rca_pkg::*;
#(
    parameter int WIDTH = RCA_WIDTH_DEFAULT
);
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             cin;
    logic [WIDTH-1:0] sum;
    logic             c4;

    modport master (
        output a,
        output b,
        output cin,
        input  sum,
        input  c4
    );

    modport slave (
        input  a,
        input  b,
        input  cin,
        output sum,
        output c4
    );
endinterface : rca_if

// File: rtl/rca_full_adder.sv
// Purpose: single-bit full adder, one stage of the ripple chain.
// Latency: combinational.
// Backpressure: none.
//
// Ports: x, y - addend bits; ci - carry in; s - sum bit; co - carry out.
module full_adder (
    input  logic x,
    input  logic y,
    input  logic ci,
    output logic s,
    output logic co
);
    logic p;

    // Propagate term is shared between the sum and the carry.
    assign p  = x ^ y;
    assign s  = p ^ ci;
    assign co = (x & y) | (ci & p);
endmodule : full_adder

// File: rtl/rca.sv
// Purpose: WIDTH-bit ripple-carry adder with registered {c4, sum}.
// Latency: one clk; operands before edge N appear on sum/c4 after edge N.
// Backpressure: none; accepts a new operand set every cycle.
//
// Ports:
//   clk - system clock, all state on its rising edge
//   rst - synchronous active-high reset, clears sum and c4
//   bus - rca_if slave: a, b, cin in (unregistered); sum, c4 out
module rca
    import rca_pkg::*;
#(
    parameter int WIDTH = RCA_WIDTH_DEFAULT
) (
    input  logic  clk,
    input  logic  rst,
    rca_if.slave  bus
);
    // carry[i] feeds stage i; carry[WIDTH] is the carry out of the MSB.
    logic [WIDTH:0]   carry;
    logic [WIDTH-1:0] sum_d;
    logic             c4_d;
    logic [WIDTH-1:0] sum_q;
    logic             c4_q;

    assign carry[0] = bus.cin;

    for (genvar i = 0; i < WIDTH; i++) begin : g_stage
        full_adder u_fa (
            .x  (bus.a[i]),
            .y  (bus.b[i]),
            .ci (carry[i]),
            .s  (sum_d[i]),
            .co (carry[i+1])
        );
    end

    assign c4_d = carry[WIDTH];

    // The only storage in the block: WIDTH+1 result flops.
    always_ff @(posedge clk) begin
        if (rst) begin
            sum_q <= '0;
            c4_q  <= 1'b0;
        end else begin
            sum_q <= sum_d;
            c4_q  <= c4_d;
        end
    end

    assign bus.sum = sum_q;
    assign bus.c4  = c4_q;
endmodule : rca

// File: tb/tb_rca.sv
module tb_rca;
    import rca_pkg::*;

    localparam int W = RCA_WIDTH_DEFAULT;

    typedef struct {
        int           due;
        logic [W-1:0] s;
        logic         c;
        string        tag;
    } exp_t;

    logic clk;
    logic rst;
    int   cyc;
    int   vectors;
    int   miscompares;
    exp_t sb[$];
    exp_t mon_e;

    rca_if #(.WIDTH(W)) bus ();

    rca #(.WIDTH(W)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    // Monitor: each clock the DUT presents one result; compare it with the
    // oldest scoreboard entry that has come due.
    always @(negedge clk) begin
        if (sb.size() > 0 && sb[0].due <= cyc) begin
            mon_e = sb.pop_front();
            vectors++;
            if (mon_e.due != cyc || bus.sum !== mon_e.s || bus.c4 !== mon_e.c) begin
                miscompares++;
                $display("FAIL %s: got sum=%b c4=%b at cycle %0d, expected sum=%b c4=%b at cycle %0d",
                         mon_e.tag, bus.sum, bus.c4, cyc, mon_e.s, mon_e.c, mon_e.due);
            end
        end
    end

    // Drive one cycle of stimulus and queue the result expected after the
    // next rising edge.
    task automatic apply_exp(input logic r, input int av, input int bv, input int cv,
                             input int es, input int ec, input string tag);
        exp_t e;
        @(posedge clk);
        #1;
        rst     = r;
        bus.a   = W'(av);
        bus.b   = W'(bv);
        bus.cin = cv[0];
        e.due = cyc + 1;
        e.s   = W'(es);
        e.c   = ec[0];
        e.tag = tag;
        sb.push_back(e);
    endtask

    // Reference: plain integer addition, split into low W bits and carry.
    task automatic apply(input logic r, input int av, input int bv, input int cv,
                         input string tag);
        int total;
        total = av + bv + cv;
        if (r)
            apply_exp(r, av, bv, cv, 0, 0, tag);
        else
            apply_exp(r, av, bv, cv, total % (1 << W), (total >= (1 << W)) ? 1 : 0, tag);
    endtask

    initial begin
        int drain;
        cyc         = 0;
        vectors     = 0;
        miscompares = 0;
        rst         = 1'b1;
        bus.a       = '0;
        bus.b       = '0;
        bus.cin     = 1'b0;

        // Reset state.
        apply(1'b1, 0, 0, 0, "reset_init0");
        apply(1'b1, 0, 0, 0, "reset_init1");

        // Directed cases with hand-computed results.
        apply_exp(1'b0, 4'b0110, 4'b1100, 0, 4'b0010, 1, "dir_0110_1100");
        apply_exp(1'b0, 4'b1110, 4'b1000, 0, 4'b0110, 1, "dir_1110_1000");
        apply_exp(1'b0, 4'b0111, 4'b1110, 0, 4'b0101, 1, "dir_0111_1110");
        apply_exp(1'b0, 4'b0010, 4'b1001, 0, 4'b1011, 0, "dir_0010_1001");
        apply_exp(1'b0, 4'b1111, 4'b0000, 1, 4'b0000, 1, "dir_full_ripple");
        apply_exp(1'b0, 4'b1111, 4'b1111, 1, 4'b1111, 1, "dir_max");
        apply_exp(1'b0, 4'b0000, 4'b0000, 0, 4'b0000, 0, "dir_zero");

        // Reset held two cycles with all-ones operands, then release.
        apply_exp(1'b0, 4'b1111, 4'b1110, 0, 4'b1101, 1, "pre_reset");
        apply_exp(1'b1, 4'b1111, 4'b1111, 1, 4'b0000, 0, "reset_ones0");
        apply_exp(1'b1, 4'b1111, 4'b1111, 1, 4'b0000, 0, "reset_ones1");
        apply_exp(1'b0, 4'b1111, 4'b1111, 0, 4'b1110, 1, "post_reset");

        // Exhaustive back-to-back sweep of every (a, b, cin).
        for (int c = 0; c < 2; c++)
            for (int i = 0; i < (1 << W); i++)
                for (int j = 0; j < (1 << W); j++)
                    apply(1'b0, i, j, c, "sweep");

        // Random back-to-back operands with occasional mid-stream reset.
        for (int k = 0; k < 300; k++)
            apply(($urandom_range(0, 15) == 0) ? 1'b1 : 1'b0,
                  int'($urandom_range(0, (1 << W) - 1)),
                  int'($urandom_range(0, (1 << W) - 1)),
                  int'($urandom_range(0, 1)), "random");

        // Drain the scoreboard within a bounded number of cycles.
        drain = 0;
        while (sb.size() > 0 && drain < 10) begin
            @(posedge clk);
            drain++;
        end
        @(negedge clk);
        #1;
        if (sb.size() != 0) begin
            miscompares++;
            $display("FAIL drain: %0d results outstanding, expected 0", sb.size());
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached, expected completion");
        $fatal(1, "watchdog");
    end
endmodule : tb_rca

// File: doc/rca.md
RCA -- requirements
Module: rca

Interface
REQ-001 Parameter WIDTH, default 4: operand and sum width in bits; legal range 1..32.
REQ-002 clk  input  1  system clock; all state updates on its rising edge.
REQ-003 rst  input  1  reset, synchronous, active-high.
REQ-004 a  input  WIDTH  first unsigned addend.
REQ-005 b  input  WIDTH  second unsigned addend.
REQ-006 cin  input  1  carry into bit 0.
REQ-007 sum  output  WIDTH  registered sum bits, a+b+cin modulo 2^WIDTH.
REQ-008 c4  output  1  registered carry out of the most significant bit.
REQ-009 The block SHALL use exactly one clock (clk), and reset SHALL be synchronous and active-high (rst).

Function
REQ-010 The adder SHALL be a ripple-carry chain of WIDTH full-adder stages: stage 0 takes cin; stage i takes the carry out of stage i-1; c4 is the carry out of stage WIDTH-1.
REQ-011 Each stage SHALL compute s = x XOR y XOR ci and co = (x AND y) OR (ci AND (x XOR y)).
REQ-012 {c4, sum} SHALL equal a + b + cin as a (WIDTH+1)-bit unsigned result, with no truncation of the carry.
REQ-013 a, b and cin SHALL NOT be registered; the ripple result SHALL be captured into the sum/c4 registers on each rising clk edge when rst is low.
REQ-014 Latency SHALL be exactly one clock: operands stable before edge N appear on sum/c4 after edge N and hold until the next edge.
REQ-015 The adder SHALL accept a new operand set every cycle, with no handshake, stall or valid signal.
REQ-016 Overflow SHALL wrap sum modulo 2^WIDTH and set c4=1; no saturation.
REQ-017 Maximum case: a=b=all-ones with cin=1 SHALL give sum=all-ones and c4=1.
REQ-018 Zero case: a=b=0 with cin=0 SHALL give sum=0 and c4=0.
REQ-019 X/Z on inputs is out of scope; outputs are not required to be defined in that case.

Reset
REQ-020 While rst is high at a rising clk edge, sum SHALL load 0 and c4 SHALL load 0, regardless of a, b and cin.
REQ-021 If rst is asserted mid-stream, the result in flight SHALL be discarded; the first valid result SHALL appear one edge after the first edge with rst low.
REQ-022 rst SHALL have no asynchronous effect; outputs change only on clk edges.

Structure
REQ-023 A shared package SHALL hold the constant RCA_WIDTH_DEFAULT = 4, which is used as the default for WIDTH.
REQ-024 One sub-module, full_adder (ports x, y, ci, s, co; purely combinational), SHALL be instantiated WIDTH times by a generate loop.
REQ-025 The only storage SHALL be the output register bank (WIDTH+1 flops); there SHALL be no carry-lookahead or other prefix logic.

Verification (WIDTH=4, cin=0 unless stated, checked one cycle after applying the operands)
REQ-026 a=0110, b=1100 -> sum=0010, c4=1; then a=1110, b=1000 -> sum=0110, c4=1.
REQ-027 a=0111, b=1110 -> sum=0101, c4=1; then a=0010, b=1001 -> sum=1011, c4=0.
REQ-028 a=1111, b=0000, cin=1 -> sum=0000, c4=1 (full carry ripple); a=1111, b=1111, cin=1 -> sum=1111, c4=1.
REQ-029 Back-to-back operand changes on every cycle -> each result appears exactly one cycle later with no bubbles.
REQ-030 rst=1 for 2 cycles while a=1111, b=1111 -> sum=0000, c4=0; after release, correct results from the next edge.
REQ-031 Exhaustive sweep of all 512 (a, b, cin) combinations -> {c4, sum} == a+b+cin for every combination, compared against a reference model.
